// File: rtl/mem_bus_arbiter_if.sv
// Shared bus bundle for mem_bus_arbiter: fetch port, data port, memory port.
// master = requesters plus memory model, slave = the arbiter.
interface mem_bus_arbiter_if #(
    parameter int WORD      = 64,
    parameter int INST_SIZE = 32
);
    logic                 i_req;
    logic [WORD-1:0]      i_addr;
    logic [INST_SIZE-1:0] i_rdata;
    logic                 i_ack;
    logic                 i_err;

    logic                 d_req;
    logic                 d_we;
    logic [WORD-1:0]      d_addr;
    logic [WORD-1:0]      d_wdata;
    logic [WORD-1:0]      d_rdata;
    logic                 d_ack;
    logic                 d_err;

    logic                 m_req;
    logic                 m_we;
    logic [WORD-1:0]      m_addr;
    logic [WORD-1:0]      m_wdata;
    logic [WORD-1:0]      m_rdata;
    logic                 m_ack;

    logic                 busy;

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata,
        output m_rdata, m_ack,
        input  i_rdata, i_ack, i_err, d_rdata, d_ack, d_err,
        input  m_req, m_we, m_addr, m_wdata, busy
    );

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata,
        input  m_rdata, m_ack,
        output i_rdata, i_ack, i_err, d_rdata, d_ack, d_err,
        output m_req, m_we, m_addr, m_wdata, busy
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Arbitrates a fetch and a data requester onto one memory port,
// with tie policy, BUSY-phase timeout abort and one-cycle acks.
module mem_bus_arbiter #(
    parameter int WORD      = 64,
    parameter int INST_SIZE = 32,
    parameter int DATA_PRIO = 1,
    parameter int TIMEOUT   = 255
) (
    input logic              clk,
    input logic              rst_n,
    mem_bus_arbiter_if.slave bus
);
    typedef enum logic [1:0] { IDLE, BUSY, RESP } state_t;

    localparam logic [15:0] TO = 16'(TIMEOUT);

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_gnt_d;
    logic                 w_gnt_d;
    logic                 w_req_any;
    logic [15:0]          r_cnt;
    logic [15:0]          w_cnt_inc;
    logic                 w_timeout;
    logic                 r_err;
    logic                 r_isel;
    logic                 r_m_we;
    logic [WORD-1:0]      r_m_addr;
    logic [WORD-1:0]      r_m_wdata;
    logic [WORD-1:0]      r_d_rdata;
    logic [INST_SIZE-1:0] r_i_rdata;
    logic [INST_SIZE-1:0] w_i_word;

    assign w_req_any = bus.i_req | bus.d_req;
    assign w_cnt_inc = r_cnt + 16'd1;
    assign w_timeout = (TIMEOUT != 0) && (w_cnt_inc == TO) && !bus.m_ack;
    assign w_i_word  = r_isel ? bus.m_rdata[2*INST_SIZE-1:INST_SIZE]
                              : bus.m_rdata[INST_SIZE-1:0];

    assign bus.m_req   = (r_state == BUSY);
    assign bus.busy    = (r_state != IDLE);
    assign bus.i_ack   = (r_state == RESP) && !r_gnt_d;
    assign bus.d_ack   = (r_state == RESP) && r_gnt_d;
    assign bus.i_err   = bus.i_ack && r_err;
    assign bus.d_err   = bus.d_ack && r_err;
    assign bus.m_we    = r_m_we;
    assign bus.m_addr  = r_m_addr;
    assign bus.m_wdata = r_m_wdata;
    assign bus.i_rdata = r_i_rdata;
    assign bus.d_rdata = r_d_rdata;

    // Winner of an IDLE grant; r_gnt_d doubles as the last-grant record
    always_comb begin
        w_gnt_d = r_gnt_d;
        unique case (1'b1)
            bus.i_req && bus.d_req:
                w_gnt_d = (DATA_PRIO != 0) ? 1'b1 : ~r_gnt_d;
            bus.d_req && !bus.i_req:
                w_gnt_d = 1'b1;
            bus.i_req && !bus.d_req:
                w_gnt_d = 1'b0;
            default:
                w_gnt_d = r_gnt_d;
        endcase
    end

    // Next-state logic: grant, wait for memory or timeout, one ack cycle
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (w_req_any) w_state_nxt = BUSY;
            BUSY:    if (bus.m_ack || w_timeout) w_state_nxt = RESP;
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Command latch at grant, timeout counter, response capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt_d   <= 1'b0;
            r_cnt     <= '0;
            r_err     <= 1'b0;
            r_isel    <= 1'b0;
            r_m_we    <= 1'b0;
            r_m_addr  <= '0;
            r_m_wdata <= '0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    r_err <= 1'b0;
                    if (w_req_any) begin
                        r_gnt_d   <= w_gnt_d;
                        r_m_we    <= w_gnt_d & bus.d_we;
                        r_m_addr  <= w_gnt_d ? bus.d_addr : bus.i_addr;
                        r_m_wdata <= w_gnt_d ? bus.d_wdata : '0;
                        r_isel    <= bus.i_addr[2];
                    end
                end
                BUSY: begin
                    if (bus.m_ack) begin
                        r_cnt <= '0;
                        r_err <= 1'b0;
                        if (!r_gnt_d)     r_i_rdata <= w_i_word;
                        else if (!r_m_we) r_d_rdata <= bus.m_rdata;
                    end else if (w_timeout) begin
                        r_cnt <= '0;
                        r_err <= 1'b1;
                        if (!r_gnt_d)     r_i_rdata <= '0;
                        else if (!r_m_we) r_d_rdata <= '0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: transaction-schedule model with random traffic
// on a data-priority instance, plus a round-robin instance held saturated.
module tb_mem_bus_arbiter;
    localparam int W  = 64;
    localparam int IS = 32;

    logic clk = 1'b0;
    logic rst_n;
    logic rst1_n;
    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.WORD(W), .INST_SIZE(IS)) b0 ();
    mem_bus_arbiter_if #(.WORD(W), .INST_SIZE(IS)) b1 ();

    mem_bus_arbiter #(.WORD(W), .INST_SIZE(IS), .DATA_PRIO(1), .TIMEOUT(4)) u0 (
        .clk(clk), .rst_n(rst_n), .bus(b0)
    );
    mem_bus_arbiter #(.WORD(W), .INST_SIZE(IS), .DATA_PRIO(0), .TIMEOUT(0)) u1 (
        .clk(clk), .rst_n(rst1_n), .bus(b1)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit u1_fin = 0;

    // model of u0: a transaction is a schedule of L request cycles plus one ack
    int          age = 0;
    int          L = 0;
    int          dly = 0;
    bit          g_d = 0;
    bit          t_err = 0;
    bit          t_we = 0;
    logic [63:0] t_addr = '0;
    logic [63:0] t_wdata = '0;
    bit          i_pend = 0;
    bit          d_pend = 0;
    bit          d_w = 0;
    logic [63:0] i_a = '0;
    logic [63:0] d_a = '0;
    logic [63:0] d_wd = '0;
    logic [31:0] e_irdata = '0;
    logic [63:0] e_drdata = '0;
    bit          dir_mode = 1;
    int          force_d = 0;
    bit          force_rd_en = 0;
    logic [63:0] force_rd = '0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // one clock of u0: drive inputs, advance the model, compare after the edge
    task automatic step();
        logic [63:0] rd;
        bit in_busy;
        bit rsp;
        in_busy = (age >= 1) && (age <= L);
        rsp = (age != 0) && (age == L + 1);
        if (rsp) begin
            if (g_d) d_pend = 0;
            else     i_pend = 0;
        end
        if (!dir_mode) begin
            if (!i_pend && $urandom_range(0, 2) == 0) begin
                i_pend = 1;
                i_a = {$urandom, $urandom};
            end
            if (!d_pend && $urandom_range(0, 2) == 0) begin
                d_pend = 1;
                d_a = {$urandom, $urandom};
                d_wd = {$urandom, $urandom};
                d_w = 1'($urandom_range(0, 1));
            end
        end
        rd = force_rd_en ? force_rd : {$urandom, $urandom};
        b0.i_req = i_pend;
        b0.i_addr = i_a;
        b0.d_req = d_pend;
        b0.d_we = d_w;
        b0.d_addr = d_a;
        b0.d_wdata = d_wd;
        b0.m_rdata = rd;
        b0.m_ack = in_busy ? (age == dly) : ($urandom_range(0, 3) == 0);
        if (age == 0) begin
            if (i_pend || d_pend) begin
                g_d = d_pend;
                t_we = g_d && d_w;
                t_addr = g_d ? d_a : i_a;
                t_wdata = d_wd;
                dly = (force_d != 0) ? force_d : $urandom_range(1, 6);
                L = (dly <= 4) ? dly : 4;
                t_err = (dly > 4);
                age = 1;
            end
        end else if (age <= L) begin
            if (age == L) begin
                if (g_d) begin
                    if (!t_we) e_drdata = t_err ? 64'h0 : rd;
                end else begin
                    e_irdata = t_err ? 32'h0 : (t_addr[2] ? rd[63:32] : rd[31:0]);
                end
            end
            age++;
        end else begin
            age = 0;
        end
        @(posedge clk);
        #1;
        in_busy = (age >= 1) && (age <= L);
        rsp = (age != 0) && (age == L + 1);
        chk("busy", b0.busy, age != 0);
        chk("m_req", b0.m_req, in_busy);
        chk("i_ack", b0.i_ack, rsp && !g_d);
        chk("d_ack", b0.d_ack, rsp && g_d);
        chk("i_err", b0.i_err, rsp && !g_d && t_err);
        chk("d_err", b0.d_err, rsp && g_d && t_err);
        chk("i_rdata", b0.i_rdata, e_irdata);
        chk("d_rdata", b0.d_rdata, e_drdata);
        if (in_busy) begin
            chk("m_addr", b0.m_addr, t_addr);
            chk("m_we", b0.m_we, t_we);
            if (g_d) chk("m_wdata", b0.m_wdata, t_wdata);
        end
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        for (int n = 0; n < 50 && !ok; n++) begin
            if (age == 0 && !i_pend && !d_pend) ok = 1;
            else step();
        end
        if (!ok) chk("drain_timeout", 0, 1);
    endtask

    task automatic fetch_txn(input logic [63:0] a, input int d,
                             input logic [63:0] rdv, output int ncyc,
                             output int nreq);
        bit done;
        i_pend = 1;
        i_a = a;
        force_d = d;
        force_rd_en = 1;
        force_rd = rdv;
        nreq = 0;
        done = 0;
        step();
        ncyc = 1;
        for (int n = 0; n < 20 && !done; n++) begin
            if (b0.i_ack) begin
                done = 1;
            end else begin
                if (b0.m_req) nreq++;
                step();
                ncyc++;
            end
        end
        chk("fetch_ack_seen", done, 1);
        force_rd_en = 0;
        force_d = 0;
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_m_req"}, b0.m_req, 0);
        chk({nm, "_busy"}, b0.busy, 0);
        chk({nm, "_i_ack"}, b0.i_ack, 0);
        chk({nm, "_d_ack"}, b0.d_ack, 0);
        chk({nm, "_i_err"}, b0.i_err, 0);
        chk({nm, "_d_err"}, b0.d_err, 0);
        chk({nm, "_m_addr"}, b0.m_addr, 0);
        chk({nm, "_m_wdata"}, b0.m_wdata, 0);
        chk({nm, "_i_rdata"}, b0.i_rdata, 0);
        chk({nm, "_d_rdata"}, b0.d_rdata, 0);
    endtask

    initial begin : main
        int nc;
        int nr;
        int seq[$];
        bit ok;
        rst_n = 1'b0;
        b0.i_req = 0; b0.i_addr = '0; b0.d_req = 0; b0.d_we = 0;
        b0.d_addr = '0; b0.d_wdata = '0; b0.m_ack = 0; b0.m_rdata = '0;
        repeat (2) begin
            @(posedge clk);
            #1;
            check_zero("reset");
        end
        rst_n = 1'b1;

        // fetch at 0x104, memory acks on third request cycle
        fetch_txn(64'h104, 3, 64'hAAAA_BBBB_CCCC_DDDD, nc, nr);
        chk("t1_latency", nc, 4);
        chk("t1_rdata", b0.i_rdata, 32'hAAAABBBB);
        chk("t1_err", b0.i_err, 0);
        drain();

        // simultaneous requests: data first, then fetch
        i_pend = 1; i_a = 64'h200;
        d_pend = 1; d_a = 64'h300; d_w = 0;
        force_d = 2; force_rd_en = 1; force_rd = 64'h0123_4567_89AB_CDEF;
        ok = 0;
        for (int n = 0; n < 30 && !ok; n++) begin
            step();
            if (b0.d_ack) seq.push_back(1);
            if (b0.i_ack) seq.push_back(0);
            if (seq.size() >= 2) ok = 1;
        end
        chk("t2_two_acks", ok, 1);
        if (ok) begin
            chk("t2_first_data", seq[0], 1);
            chk("t2_second_fetch", seq[1], 0);
        end
        chk("t2_d_rdata", b0.d_rdata, 64'h0123_4567_89AB_CDEF);
        chk("t2_i_rdata", b0.i_rdata, 32'h89AB_CDEF);
        drain();

        // data write must not disturb d_rdata
        d_pend = 1; d_a = 64'h40; d_wd = 64'h1234; d_w = 1;
        force_d = 2; force_rd = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        chk("t3_m_we", b0.m_we, 1);
        chk("t3_m_addr", b0.m_addr, 64'h40);
        chk("t3_m_wdata", b0.m_wdata, 64'h1234);
        ok = 0;
        for (int n = 0; n < 10 && !ok; n++) begin
            step();
            if (b0.d_ack) ok = 1;
        end
        chk("t3_ack_seen", ok, 1);
        chk("t3_d_rdata_kept", b0.d_rdata, 64'h0123_4567_89AB_CDEF);
        force_rd_en = 0; force_d = 0;
        d_w = 0;
        drain();

        // memory never answers: abort after 4 request cycles
        fetch_txn(64'h8, 6, 64'h5555_6666_7777_8888, nc, nr);
        chk("t4_mreq_cycles", nr, 4);
        chk("t4_err", b0.i_err, 1);
        chk("t4_rdata", b0.i_rdata, 0);
        drain();

        // ack on the last allowed cycle wins over the timeout
        fetch_txn(64'h0, 4, 64'h1111_2222_3333_4444, nc, nr);
        chk("t5_mreq_cycles", nr, 4);
        chk("t5_err", b0.i_err, 0);
        chk("t5_rdata", b0.i_rdata, 32'h3333_4444);
        drain();

        dir_mode = 0;
        repeat (3000) step();
        dir_mode = 1;
        drain();

        // reset while the memory port is busy
        d_pend = 1; d_a = 64'h77; d_w = 0; force_d = 6;
        step();
        step();
        chk("t6_busy_before", b0.m_req, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("t6_rst");
        age = 0; i_pend = 0; d_pend = 0; force_d = 0;
        e_irdata = '0; e_drdata = '0;
        b0.i_req = 0; b0.d_req = 0; b0.m_ack = 0;
        @(posedge clk);
        #1;
        check_zero("t6_hold");
        rst_n = 1'b1;
        fetch_txn(64'h10, 1, 64'h0000_0000_CAFE_F00D, nc, nr);
        chk("t6_latency", nc, 2);
        chk("t6_rdata", b0.i_rdata, 32'hCAFE_F00D);
        chk("t6_err", b0.i_err, 0);
        drain();

        for (int n = 0; n < 5000 && !u1_fin; n++) @(posedge clk);
        chk("u1_finished", u1_fin, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // round-robin instance: both requesters always asserted, no timeout
    initial begin : u1_run
        int got;
        int j;
        int dl;
        rst1_n = 1'b0;
        b1.i_req = 1; b1.i_addr = 64'h1000;
        b1.d_req = 1; b1.d_we = 1; b1.d_addr = 64'h2000; b1.d_wdata = 64'h5;
        b1.m_ack = 0; b1.m_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        rst1_n = 1'b1;
        got = 0;
        j = 0;
        dl = 2;
        for (int c = 0; c < 3000 && got < 8; c++) begin
            if (b1.d_ack || b1.i_ack) begin
                chk("u1_grant_is_data", b1.d_ack, (got % 2) == 0);
                chk("u1_err", b1.i_err | b1.d_err, 0);
                got++;
                j = 0;
                dl = (got == 2) ? 300 : $urandom_range(1, 3);
            end
            if (b1.m_req) j++;
            b1.m_ack = b1.m_req && (j == dl);
            b1.m_rdata = {$urandom, $urandom};
            @(posedge clk);
            #1;
        end
        chk("u1_acks", got, 8);
        u1_fin = 1;
    end
endmodule
